// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the load/store path, plus the responder FSM state
// type and the access-size helper.
package dbus_responder_pkg;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } dresp_state_t;

   function automatic logic [3:0] msize_bytes(input msize_t sz);
      logic [3:0] n;
      case (sz)
         MSIZE1:  n = 4'd1;
         MSIZE2:  n = 4'd2;
         MSIZE4:  n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dbus_responder_mem.sv
// DEPTH x 64 word store: one asynchronous read port and one byte-strobed
// synchronous write port. Contents are never reset.
module dbus_responder_mem #(
   parameter int DEPTH = 1024
) (
   input  logic                     i_clk,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [63:0]              o_rdata,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [7:0]               i_strobe,
   input  logic [63:0]              i_wdata
);

   logic [63:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_raddr];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (i_strobe[i]) begin
               r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder backed by dbus_responder_mem.
// Optional alignment check: define DBUS_RESPONDER_ALIGN_CHECK_EN.
module dbus_responder
   import dbus_responder_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       err
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

   dresp_state_t  r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [63:0]   r_addr;
   logic [63:0]   r_data;
   msize_t        r_size;
   logic [7:0]    r_strobe;

   logic [IW-1:0] w_idx;
   logic [63:0]   w_rdata;
   logic          w_misaligned;
   logic          w_we;
   logic          w_unused;

   assign w_idx = r_addr[3 +: IW];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr   <= '0;
         r_data   <= '0;
         r_size   <= MSIZE1;
         r_strobe <= '0;
      end else if (r_state == IDLE && dreq.valid) begin
         r_addr   <= dreq.addr;
         r_data   <= dreq.data;
         r_size   <= dreq.size;
         r_strobe <= dreq.strobe;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (dreq.valid) begin
               w_cnt_nxt   = CW'(LATENCY - 1);
               w_state_nxt = (LATENCY == 1) ? DONE : BUSY;
            end
         end
         BUSY: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
   logic [2:0] w_amask;
   assign w_amask      = 3'(msize_bytes(r_size) - 4'd1);
   assign w_misaligned = (r_addr[2:0] & w_amask) != 3'b000;
`else
   assign w_misaligned = 1'b0;
`endif

   // Only the index bits (and, with the check, the low bits and size) matter.
   assign w_unused = ^{r_addr, r_size};

   always_comb begin
      dresp = '0;
      err   = 1'b0;
      if (r_state == DONE) begin
         dresp.addr_ok = 1'b1;
         dresp.data_ok = 1'b1;
         dresp.data    = w_misaligned ? '0 : w_rdata;
         err           = w_misaligned;
      end
   end

   assign w_we = (r_state == DONE) && (r_strobe != '0) && !w_misaligned;

   dbus_responder_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .i_clk    (clk),
      .i_raddr  (w_idx),
      .o_rdata  (w_rdata),
      .i_we     (w_we),
      .i_waddr  (w_idx),
      .i_strobe (r_strobe),
      .i_wdata  (r_data)
   );

endmodule

// File: tb/tb_dbus_responder.sv
// Directed and randomized bench for dbus_responder against a byte-level
// reference memory model.
module tb_dbus_responder;
   import dbus_responder_pkg::*;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
`ifdef DBUS_RESPONDER_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   dbus_req_t  dreq = '0;
   dbus_resp_t dresp;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [63:0] ref_mem   [DEPTH];
   logic [7:0]  ref_known [DEPTH];

   dbus_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .dreq  (dreq),
      .dresp (dresp),
      .err   (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int m_idx(input logic [63:0] a);
      return int'((a / 64'd8) % 64'(DEPTH));
   endfunction

   function automatic bit m_mis(input logic [63:0] a, input msize_t sz);
      int unsigned nb;
      nb = 1 << int'(sz);
      return ALIGN && ((a % 64'(nb)) != 64'd0);
   endfunction

   // One full transaction starting at a negedge with the DUT idle; ends at the
   // negedge of the first idle cycle after data_ok.
   task automatic txn(input logic [63:0] a, input msize_t sz, input logic [7:0] st,
                      input logic [63:0] d, input bit drop);
      int          k;
      logic [63:0] exp_d, m;
      bit          mis;
      k   = m_idx(a);
      mis = m_mis(a, sz);
      for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{ref_known[k][b]}};
      exp_d = ref_mem[k];
      if (mis) begin
         exp_d = '0;
         m     = '1;
      end
      dreq.valid  = 1'b1;
      dreq.addr   = a;
      dreq.size   = sz;
      dreq.strobe = st;
      dreq.data   = d;
      #1;
      chk("data_ok_c0", 64'(dresp.data_ok), 64'd0);
      for (int c = 1; c <= LAT + 1; c++) begin
         @(negedge clk);
         chk("data_ok_cyc", 64'(dresp.data_ok), 64'(c == LAT));
         if (c == 1 && drop) begin
            dreq.valid  = 1'b0;
            dreq.addr   = ~a;
            dreq.data   = ~d;
            dreq.strobe = ~st;
         end
         if (c == LAT) begin
            chk("addr_ok", 64'(dresp.addr_ok), 64'd1);
            chk("err", 64'(err), 64'(mis));
            if (m != '0) chk("rdata", dresp.data & m, exp_d & m);
            dreq.valid = 1'b0;
         end
         if (c == LAT + 1) begin
            chk("data_idle", dresp.data, 64'd0);
         end
      end
      if (st != 8'h00 && !mis) begin
         for (int b = 0; b < 8; b++) begin
            if (st[b]) begin
               ref_mem[k][8*b +: 8] = d[8*b +: 8];
               ref_known[k][b]      = 1'b1;
            end
         end
      end
   endtask

   // Write that is killed by reset after `cyc` cycles; memory must not change.
   task automatic aborted_write(input logic [63:0] a, input logic [63:0] d, input int cyc);
      dreq.valid  = 1'b1;
      dreq.addr   = a;
      dreq.size   = MSIZE8;
      dreq.strobe = 8'hFF;
      dreq.data   = d;
      for (int c = 1; c <= cyc; c++) @(negedge clk);
      chk("pre_rst_data_ok", 64'(dresp.data_ok), 64'(cyc == LAT));
      reset = 1'b0;
      #1;
      chk("rst_data_ok", 64'(dresp.data_ok), 64'd0);
      chk("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
      chk("rst_data", dresp.data, 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      dreq.valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_data_ok", 64'(dresp.data_ok), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] ra;
      msize_t      rs;
      logic [7:0]  rst_b;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]   = '0;
         ref_known[i] = '0;
      end

      repeat (3) @(negedge clk);
      chk("reset_data_ok", 64'(dresp.data_ok), 64'd0);
      chk("reset_addr_ok", 64'(dresp.addr_ok), 64'd0);
      chk("reset_data", dresp.data, 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      txn(64'h80, MSIZE8, 8'hFF, 64'h1122334455667788, 1'b0);
      txn(64'h80, MSIZE8, 8'h00, 64'h0, 1'b0);
      txn(64'h80, MSIZE8, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0);
      txn(64'h80, MSIZE8, 8'h00, 64'h0, 1'b0);
      txn(64'h2080, MSIZE8, 8'hFF, 64'hCAFEF00DDEADBEEF, 1'b0);
      txn(64'h80, MSIZE8, 8'h00, 64'h0, 1'b0);
      txn(64'h100, MSIZE8, 8'hFF, 64'h0123456789ABCDEF, 1'b1);
      txn(64'h100, MSIZE8, 8'h00, 64'h0, 1'b0);

      aborted_write(64'h80, 64'h5555666677778888, 1);
      txn(64'h80, MSIZE8, 8'h00, 64'h0, 1'b0);
      aborted_write(64'h80, 64'h9999000011112222, LAT);
      txn(64'h80, MSIZE8, 8'h00, 64'h0, 1'b0);

      txn(64'h84, MSIZE8, 8'hFF, 64'hFEDCBA9876543210, 1'b0);
      txn(64'h80, MSIZE8, 8'h00, 64'h0, 1'b0);
      txn(64'h86, MSIZE2, 8'h00, 64'h0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         ra        = {$urandom, $urandom};
         ra[12:3]  = 10'($urandom_range(0, 15));
         rs        = msize_t'($urandom_range(0, 3));
         rst_b     = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
         txn(ra, rs, rst_b, {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Memory-side responder for the core's data bus: accepts `dbus_req_t` transactions issued by the memory stage, services them from an internal word-addressed store after a fixed latency, and returns `dbus_resp_t`. It is the far end of the load/store path used by `ld`/`sd`-class instructions. It serves as the standalone data-memory model for pipeline bring-up and as the reference responder for bus-protocol checks.

## Interface
- `DEPTH`, 1024, number of 64-bit words in the store; power of two, ≥ 2
- `LATENCY`, 2, cycles from request acceptance to `data_ok`; ≥ 1
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset (low = in reset)
- `dreq`  in  `dbus_req_t`  `valid`, `addr` (64), `size` (`msize_t`), `strobe` (8), `data` (64)
- `dresp`  out  `dbus_resp_t`  `addr_ok`, `data_ok`, `data` (64)
- `err`  out  1  alignment error, pulses with `data_ok`; tied 0 unless the check is compiled in

## Operation
- Store indexed by `idx = addr[3 +: $clog2(DEPTH)]`. Upper address bits and `addr[2:0]` are ignored for indexing, so addresses wrap modulo `DEPTH*8`.
- The FSM has three states, `IDLE`, `BUSY` and `DONE`:
  - `IDLE`: when `dreq.valid`=1, latch `addr`, `size`, `strobe` and `data`, and load `cnt = LATENCY-1`. Go to `DONE` if `LATENCY`==1, else to `BUSY`.
  - `BUSY`: decrement `cnt` each cycle. When `cnt`==1, the next state is `DONE`.
  - `DONE`: drive `addr_ok`=`data_ok`=1 for exactly one cycle, with `dresp.data = mem[idx]`, the full aligned word as it was before this transaction. On the edge that leaves `DONE`, bytes `i` with `strobe[i]`=1 are written from `data[8i+:8]`. Next state is always `IDLE`.
- `strobe`==0 means read. Any nonzero `strobe` means write, and the response data still returns the old word.
- Live `dreq` is never consulted outside `IDLE`; the latched copy is authoritative.
- The initiator holds `valid` until `data_ok`. If `valid` drops or the request changes mid-transaction, the latched transaction still completes, the write still commits, and `data_ok` still pulses. There is no abort.
- The request still visible in the `DONE` cycle is not re-accepted. The next acceptance is evaluated in the following `IDLE` cycle.

## Timing
- Reset (`reset`=0, asynchronous): the FSM goes to `IDLE`, `cnt`=0, and `dresp` and `err` are all 0.
- Memory contents are not reset and are preserved across reset. A write pending when reset asserts is discarded.
- A request first visible in cycle 0 is accepted at the end of cycle 0, and `data_ok` is high in cycle `LATENCY`.
- Steady-state throughput is one transaction per `LATENCY+1` cycles.
- `dresp.data` is valid only while `data_ok`=1 and is 0 otherwise.
- A read of index k in the cycle right after a write to k completed returns the new data.

## Configuration
- `DBUS_RESPONDER_ALIGN_CHECK_EN` defined:
  - A transaction whose latched `addr` is not a multiple of the `size` byte count (1/2/4/8) is flagged as misaligned.
  - For a misaligned transaction, the write is suppressed, `dresp.data`=0, and `err`=1 in the `DONE` cycle.
  - Timing is unchanged.
- Macro not defined: no check is performed, `err` is constant 0, and misaligned accesses behave per `strobe` and `idx` only.

## Structure
- The shared package holds:
  - `dresp_state_t` (`IDLE`, `BUSY`, `DONE`)
  - the function `msize_bytes(msize_t)` returning 1/2/4/8
  - the `dbus_req_t`/`dbus_resp_t`/`msize_t` types already shared by the pipeline
- Sub-module `dbus_responder_mem`: a `DEPTH`×64 array with one asynchronous read port and one byte-strobed synchronous write port, no reset. The FSM, counter and latches stay in `dbus_responder`.

## Test plan
- Reset, then write `addr`=0x80, `strobe`=0xFF, `data`=0x1122334455667788 with `LATENCY`=2 → `data_ok` high in cycle 2 only. A subsequent read of 0x80 returns 0x1122334455667788.
- Partial write: `strobe`=0x0F, `data`=0xAAAAAAAABBBBBBBB to 0x80 → a read of 0x80 returns 0x11223344BBBBBBBB.
- Wrap: with `DEPTH`=1024, write to 0x2080 → a read of 0x80 returns the written word.
- Valid drops in cycle 1 of a write → `data_ok` still pulses in cycle 2, and the write commits.
- Reset asserted in `BUSY` of a write → outputs go 0 immediately, no `data_ok`, and memory retains the old word.
- `DBUS_RESPONDER_ALIGN_CHECK_EN` defined: 8-byte write at 0x84 → `err`=1 with `data_ok`, `dresp.data`=0, and memory is unchanged.
